// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register in front of the EX ALU.
//   Captures one decoded instruction and resolves its operands. Each operand
//   comes from the regfile value, the EX/MEM result or the MEM/WB result, with
//   EX/MEM taking priority and x0 never forwarded. data2 can be the immediate
//   instead. While EX stalls, the held register operands are refreshed from
//   late EX/MEM or MEM/WB writes, so the values are correct when EX consumes
//   them. flush kills both the held and the incoming entry. A saturating
//   counter records the stall cycles.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   id_*              decode-side handshake and decoded fields
//   flush             redirect kill
//   exm_*, mwb_*      forwarding sources (EX/MEM, MEM/WB)
//   ex_ready/ex_valid EX-side handshake
//   alu_sel/alu_data1/alu_data2/ex_rd   registered entry presented to EX
//   stall_cnt         cycles with ex_valid & !ex_ready (saturating)

// One operand's forwarding mux. Priority is EX/MEM, then MEM/WB, then base.
module id_ex_fwd #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      i_rs,
  input  logic [XLEN-1:0] i_base,
  input  logic            i_exm_wr_en,
  input  logic [4:0]      i_exm_rd,
  input  logic [XLEN-1:0] i_exm_result,
  input  logic            i_mwb_wr_en,
  input  logic [4:0]      i_mwb_rd,
  input  logic [XLEN-1:0] i_mwb_result,
  output logic [XLEN-1:0] o_val
);
  logic w_nz, w_exm_hit, w_mwb_hit;

  assign w_nz      = (i_rs != 5'd0);
  assign w_exm_hit = w_nz & i_exm_wr_en & (i_exm_rd == i_rs);
  assign w_mwb_hit = w_nz & i_mwb_wr_en & (i_mwb_rd == i_rs);
  assign o_val     = w_exm_hit ? i_exm_result :
                     w_mwb_hit ? i_mwb_result : i_base;
endmodule

module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int SELW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [SELW-1:0] id_sel,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic            flush,
  input  logic            exm_wr_en,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_wr_en,
  input  logic [4:0]      mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [SELW-1:0] alu_sel,
  output logic [XLEN-1:0] alu_data1,
  output logic [XLEN-1:0] alu_data2,
  output logic [4:0]      ex_rd,
  output logic [CNTW-1:0] stall_cnt
);
  localparam int NOPS = 2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                      r_state, w_state_nxt;
  logic                        w_accept, w_hold;
  logic [SELW-1:0]             r_sel;
  logic [4:0]                  r_rd;
  logic                        r_use_imm;
  logic [NOPS-1:0][4:0]        r_rs;
  logic [NOPS-1:0][XLEN-1:0]   r_data;
  logic [CNTW-1:0]             r_stall_cnt;
  logic [NOPS-1:0][4:0]        w_id_rs, w_rs_sel;
  logic [NOPS-1:0][XLEN-1:0]   w_id_val, w_base, w_fwd;

  assign ex_valid  = (r_state == FULL);
  assign id_ready  = ~ex_valid | ex_ready;
  assign w_accept  = id_valid & id_ready & ~flush;
  assign w_hold    = ex_valid & ~ex_ready;

  assign alu_sel   = r_sel;
  assign alu_data1 = r_data[0];
  assign alu_data2 = r_data[1];
  assign ex_rd     = r_rd;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush)                               w_state_nxt = EMPTY;
    else if (w_accept)                       w_state_nxt = FULL;
    else if ((r_state == FULL) && ex_ready)  w_state_nxt = EMPTY;
  end

  assign w_id_rs  = {id_rs2, id_rs1};
  assign w_id_val = {id_rs2_val, id_rs1_val};

  // On accept, the mux resolves the incoming sources. Otherwise it re-examines
  // the stored sources and uses the held value as the fallback. A forwarding
  // miss then leaves the register unchanged, which is how the hold refresh works.
  for (genvar g = 0; g < NOPS; g++) begin : g_op
    assign w_rs_sel[g] = w_accept ? w_id_rs[g]  : r_rs[g];
    assign w_base[g]   = w_accept ? w_id_val[g] : r_data[g];

    id_ex_fwd #(.XLEN(XLEN)) u_fwd (
      .i_rs         (w_rs_sel[g]),
      .i_base       (w_base[g]),
      .i_exm_wr_en  (exm_wr_en),
      .i_exm_rd     (exm_rd),
      .i_exm_result (exm_result),
      .i_mwb_wr_en  (mwb_wr_en),
      .i_mwb_rd     (mwb_rd),
      .i_mwb_result (mwb_result),
      .o_val        (w_fwd[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= '0;
      r_rd      <= '0;
      r_use_imm <= 1'b0;
      r_rs      <= '0;
      r_data    <= '0;
    end else if (w_accept) begin
      r_sel     <= id_sel;
      r_rd      <= id_rd;
      r_use_imm <= id_use_imm;
      r_rs      <= w_id_rs;
      r_data[0] <= w_fwd[0];
      r_data[1] <= id_use_imm ? id_imm : w_fwd[1];
    end else if (w_hold) begin
      r_data[0] <= w_fwd[0];
      // An immediate operand has no source register, so it is never refreshed.
      if (!r_use_imm) r_data[1] <= w_fwd[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_stall_cnt <= '0;
    else if (w_hold && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        id_valid, id_ready, id_use_imm, flush;
  logic [4:0]  id_sel, id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm;
  logic        exm_wr_en, mwb_wr_en, ex_ready, ex_valid;
  logic [4:0]  exm_rd, mwb_rd, alu_sel, ex_rd;
  logic [31:0] exm_result, mwb_result, alu_data1, alu_data2;
  logic [15:0] stall_cnt;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_sel(id_sel), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .flush(flush),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_sel(alu_sel),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .ex_rd(ex_rd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  sel, rd, rs1, rs2;
    logic [31:0] d1, d2;
    logic        use_imm;
  } ent_t;

  ent_t        q[$];
  logic [15:0] cnt_m = '0;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] base);
    if (rs != 0 && exm_wr_en && exm_rd == rs) return exm_result;
    if (rs != 0 && mwb_wr_en && mwb_rd == rs) return mwb_result;
    return base;
  endfunction

  task automatic idle();
    id_valid = 0; id_sel = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_val = 0; id_rs2_val = 0; id_imm = 0; id_use_imm = 0; flush = 0;
    exm_wr_en = 0; exm_rd = 0; exm_result = 0;
    mwb_wr_en = 0; mwb_rd = 0; mwb_result = 0; ex_ready = 1;
  endtask

  task automatic drive(input logic [4:0] sel, rs1, rs2, rd,
                       input logic [31:0] v1, v2, imm, input logic ui);
    id_valid = 1; id_sel = sel; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_val = v1; id_rs2_val = v2; id_imm = imm; id_use_imm = ui;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, {31'd0, q.size() != 0});
    chk({tag, "_stall"}, {16'd0, stall_cnt}, {16'd0, cnt_m});
    if (q.size() != 0) begin
      chk({tag, "_sel"}, {27'd0, alu_sel}, {27'd0, q[0].sel});
      chk({tag, "_d1"},  alu_data1, q[0].d1);
      chk({tag, "_d2"},  alu_data2, q[0].d2);
      chk({tag, "_rd"},  {27'd0, ex_rd}, {27'd0, q[0].rd});
    end
  endtask

  // Advance one cycle. The model applies the expected effect of the current
  // inputs before the edge, and the DUT outputs are compared after it.
  task automatic tick(input string tag, input bit do_chk);
    logic rdy_m, acc;
    ent_t e;
    #1;
    rdy_m = (q.size() == 0) || ex_ready;
    if (do_chk) chk({tag, "_idready"}, {31'd0, id_ready}, {31'd0, rdy_m});
    acc = id_valid && rdy_m && !flush;
    if (rst) begin
      q.delete(); cnt_m = '0;
    end else begin
      if (q.size() != 0 && !ex_ready && cnt_m != 16'hFFFF) cnt_m++;
      if (flush) q.delete();
      else if (acc) begin
        e.sel = id_sel; e.rd = id_rd; e.rs1 = id_rs1; e.rs2 = id_rs2;
        e.use_imm = id_use_imm;
        e.d1 = fwd(id_rs1, id_rs1_val);
        e.d2 = id_use_imm ? id_imm : fwd(id_rs2, id_rs2_val);
        if (q.size() != 0) void'(q.pop_front());
        q.push_back(e);
      end else if (q.size() != 0 && ex_ready) void'(q.pop_front());
      else if (q.size() != 0) begin
        q[0].d1 = fwd(q[0].rs1, q[0].d1);
        if (!q[0].use_imm) q[0].d2 = fwd(q[0].rs2, q[0].d2);
      end
    end
    @(posedge clk); #1;
    if (do_chk) check_out(tag);
  endtask

  initial begin
    idle();
    #12;
    check_out("rst");
    chk("rst_idready", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1; rst = 0;

    // basic capture
    drive(5'd0, 5'd1, 5'd2, 5'd9, 32'd10, 32'd5, 32'd0, 1'b0);
    tick("basic", 1);

    // EX/MEM wins over MEM/WB on rs1; MEM/WB alone on rs2; unused sel code
    drive(5'd31, 5'd3, 5'd4, 5'd7, 32'h11, 32'h22, 32'd0, 1'b0);
    exm_wr_en = 1; exm_rd = 3; exm_result = 32'h7FFFFFFF;
    mwb_wr_en = 1; mwb_rd = 3; mwb_result = 32'd1;
    tick("fwd_exm", 1);
    mwb_rd = 4; mwb_result = 32'hABCD; exm_rd = 5;
    tick("fwd_mwb", 1);

    // x0 never forwarded
    drive(5'd2, 5'd0, 5'd0, 5'd1, 32'h1234, 32'h5678, 32'd0, 1'b0);
    exm_wr_en = 1; exm_rd = 0; exm_result = 32'hDEAD;
    mwb_wr_en = 1; mwb_rd = 0; mwb_result = 32'hBEEF;
    tick("x0", 1);
    idle();

    // hold for 4 cycles; MEM/WB writes rs2 in the second one
    drive(5'd1, 5'd8, 5'd6, 5'd2, 32'd3, 32'd1, 32'd0, 1'b0);
    tick("hold_acc", 1);
    drive(5'd3, 5'd9, 5'd9, 5'd3, 32'd99, 32'd98, 32'd0, 1'b0);  // must not be taken
    ex_ready = 0;
    tick("hold1", 1);
    mwb_wr_en = 1; mwb_rd = 6; mwb_result = 32'h55;
    tick("hold2", 1);
    mwb_wr_en = 0;
    tick("hold3", 1);
    tick("hold4", 1);
    chk("hold_d2", alu_data2, 32'h55);
    chk("hold_cnt", {16'd0, stall_cnt}, 32'd4);
    chk("hold_idready", {31'd0, id_ready}, 32'd0);
    idle();
    tick("drain", 1);

    // immediate operand ignores forwarding and refresh
    drive(5'd4, 5'd1, 5'd7, 5'd4, 32'd2, 32'd3, 32'hFFFFFFF0, 1'b1);
    exm_wr_en = 1; exm_rd = 7; exm_result = 32'h77;
    tick("imm", 1);
    id_valid = 0; ex_ready = 0;
    tick("imm_hold", 1);
    chk("imm_keep", alu_data2, 32'hFFFFFFF0);

    // flush kills both the held and the incoming entry
    idle(); ex_ready = 0; flush = 1;
    drive(5'd5, 5'd1, 5'd2, 5'd5, 32'd1, 32'd1, 32'd0, 1'b0);
    tick("flush", 1);
    idle();
    tick("post_flush", 1);

    // asynchronous reset mid-operation
    drive(5'd6, 5'd1, 5'd2, 5'd6, 32'hA, 32'hB, 32'd0, 1'b0);
    tick("pre_rst", 1);
    idle(); ex_ready = 0;
    #2; rst = 1; #1;
    q.delete(); cnt_m = '0;
    check_out("arst");
    chk("arst_d1", alu_data1, 32'd0);
    chk("arst_sel", {27'd0, alu_sel}, 32'd0);
    tick("arst_hold", 1);
    rst = 0;

    // back-to-back accepts with random operands and forwarding
    for (int i = 0; i < 10; i++) begin
      drive(5'($urandom_range(0, 12)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      exm_wr_en = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
      mwb_wr_en = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3)); mwb_result = $urandom;
      ex_ready = 1;
      tick("b2b", 1);
    end
    chk("b2b_cnt", {16'd0, stall_cnt}, 32'd0);

    // stall counter saturation
    idle(); ex_ready = 0;
    for (int i = 0; i < 65540; i++) tick("sat", 0);
    chk("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    check_out("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
